distance_digit_scanner: RTL
===========================

Name: distance_digit_scanner

Overview:
- Upstream stage of the telemeter 7-segment display path.
- Takes a binary distance value, converts it sequentially to 4 BCD digits with shift-and-add-3, and time-multiplexes them onto one 4-bit digit bus.
- The digit bus feeds the 7-segment decoder's 4-bit nibble input. A one-hot digit-enable bus drives the display commons.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency.
- SCAN_HZ, 1000, per-digit refresh rate. Prescaler terminal count = CLK_FREQ_HZ/SCAN_HZ - 1 (integer division).
- BIN_WIDTH, 14, width of Value. Must be at least 14.
- DIGIT_POLARITY, 0. 0 = DigitEn active-low (common anode); 1 = active-high.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Value  in  BIN_WIDTH  binary distance in cm.
- Load  in  1  one-cycle strobe; capture Value and start a conversion.
- Busy  out  1  conversion in progress.
- Overflow  out  1  last converted Value exceeded 9999.
- NbOut  out  4  nibble of the currently scanned digit, to the decoder.
- DigitEn  out  4  one-hot digit select; bit 0 = units, bit 3 = thousands.

Behaviour:
- One clock domain, Clk. Reset is asynchronous, active-high, applied to every register.
- Reset values:
  - Busy=0, Overflow=0, NbOut=0.
  - DigitEn = all inactive (4'b1111 when DIGIT_POLARITY=0, 4'b0000 when 1).
  - Display digit registers = 0, scan index = 0, prescaler = 0, FSM = IDLE.
- Conversion FSM states: IDLE, SHIFT, DONE.
  - IDLE: on Load=1, capture Value into the shift register, clear the BCD accumulator, set the overflow flag internally when Value>9999, go to SHIFT. Busy rises the next cycle.
  - SHIFT: exactly BIN_WIDTH cycles. Each cycle, add 3 to every BCD nibble that is >=5, then shift the {BCD, binary} register left by 1. Then go to DONE.
  - DONE: one cycle. Load all 4 display digit registers atomically, update Overflow, return to IDLE. Busy falls at the end of DONE.
  - Busy is high for BIN_WIDTH+1 cycles, starting the cycle after Load. New digits are visible from cycle Load+BIN_WIDTH+2.
- Overflow: when the captured Value>9999, the display digits are written as 4'hE each ("EEEE") and Overflow=1. Otherwise the BCD result is written and Overflow=0.
- Load while Busy=1 is ignored. The in-progress conversion completes unaffected.
- Load is level-sampled. Load held high in IDLE starts back-to-back conversions, each capturing Value at its own IDLE cycle.
- Scan:
  - The prescaler counts 0 to its terminal count and wraps. The tick is the cycle where the count equals the terminal count.
  - On each tick, the scan index advances 0→1→2→3→0.
  - On each tick, NbOut and DigitEn are registered from the new index. Both change on the same edge, so there is no glitch or skew between them.
  - DigitEn stays all inactive from reset until the first tick.
- Scanning runs independently of conversion. A digit update in DONE is shown at the next tick of each position. It never tears mid-digit.
- Reset mid-conversion aborts it: the FSM returns to IDLE and the digits read 0.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: during scan, a digit position whose value and all higher-position values are 0 has its DigitEn held inactive. Units (bit 0) is always enabled. No blanking applies when Overflow=1. Example: 42 enables only positions 0 and 1.
- Undefined: all 4 positions are always scanned and enabled, with leading zeros shown.

Test Plan:
- Reset asserted mid-scan and mid-SHIFT → all outputs equal their reset values immediately (asynchronous). After release, the first tick shows NbOut=0 with DigitEn bit 0 active.
- Load with Value=1234 → Busy high for 15 cycles. Scanning index 0..3 then yields NbOut 4,3,2,1. Overflow=0.
- Load with Value=10000 → scan yields NbOut E,E,E,E and Overflow=1. A following Load with Value=9999 yields 9,9,9,9 and Overflow=0.
- Load with Value=5678, then a second Load at cycle 5 of Busy with Value=1 → second Load ignored; display shows 8,7,6,5.
- Test build with CLK_FREQ_HZ=8, SCAN_HZ=2 → tick every 4 cycles, index wraps 3→0, NbOut and DigitEn change on the same edge.
- With LEADING_ZERO_BLANK_EN defined, Value=42 → positions 0 and 1 enabled, 2 and 3 inactive. Value=0 → only position 0 enabled, showing 0.

Source files
------------

// File: rtl/distance_digit_scanner.sv
// Binary distance -> 4 BCD digits (sequential shift-and-add-3), time-multiplexed onto one nibble bus.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero positions (units always shown).
module distance_digit_scanner #(
    parameter int CLK_FREQ_HZ    = 50000000,
    parameter int SCAN_HZ        = 1000,
    parameter int BIN_WIDTH      = 14,
    parameter int DIGIT_POLARITY = 0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [BIN_WIDTH-1:0] Value,
    input  logic                 Load,
    output logic                 Busy,
    output logic                 Overflow,
    output logic [3:0]           NbOut,
    output logic [3:0]           DigitEn
);
    localparam int TERM = CLK_FREQ_HZ / SCAN_HZ - 1;
    localparam int PW   = (TERM > 0) ? $clog2(TERM + 1) : 1;
    localparam int CW   = $clog2(BIN_WIDTH + 1);
    localparam logic [3:0] EN_IDLE = (DIGIT_POLARITY == 0) ? 4'b1111 : 4'b0000;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                  state_reg;
    logic [BIN_WIDTH-1:0]    bin_reg;
    logic [15:0]             bcd_reg;
    logic [CW-1:0]           shift_cnt_reg;
    logic                    ovf_pending_reg;
    logic [3:0]              digit_reg [4];

    logic [15:0]             bcd_adj;
    logic [BIN_WIDTH+15:0]   shifted;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    assign shifted = {bcd_adj, bin_reg} << 1;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg       <= IDLE;
            bin_reg         <= '0;
            bcd_reg         <= '0;
            shift_cnt_reg   <= '0;
            ovf_pending_reg <= 1'b0;
            Busy            <= 1'b0;
            Overflow        <= 1'b0;
            for (int i = 0; i < 4; i++) digit_reg[i] <= 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (Load) begin
                        bin_reg         <= Value;
                        bcd_reg         <= '0;
                        shift_cnt_reg   <= '0;
                        ovf_pending_reg <= (Value > BIN_WIDTH'(9999));
                        Busy            <= 1'b1;
                        state_reg       <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_reg, bin_reg} <= shifted;
                    shift_cnt_reg      <= shift_cnt_reg + CW'(1);
                    if (shift_cnt_reg == CW'(BIN_WIDTH - 1)) state_reg <= DONE;
                end
                DONE: begin
                    // All four digits and the flag change on one edge so the display never mixes results
                    for (int i = 0; i < 4; i++)
                        digit_reg[i] <= ovf_pending_reg ? 4'hE : bcd_reg[i*4 +: 4];
                    Overflow  <= ovf_pending_reg;
                    Busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    logic [PW-1:0] presc_reg;
    logic [1:0]    idx_reg;
    logic          scan_active_reg;
    logic          tick;
    logic [1:0]    next_idx;
    logic [3:0]    onehot;
    logic [3:0]    blank;
    logic [3:0]    en_active;

    assign tick = (presc_reg == PW'(TERM));
    // The very first tick after reset shows position 0 rather than advancing past it
    assign next_idx  = scan_active_reg ? idx_reg + 2'd1 : 2'd0;
    assign onehot    = 4'b0001 << next_idx;
    assign en_active = onehot & ~blank;

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] lead_zero;
    assign lead_zero[3] = (digit_reg[3] == 4'd0);
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lz
            assign lead_zero[gi] = (digit_reg[gi] == 4'd0) && lead_zero[gi+1];
        end
    endgenerate
    assign blank = Overflow ? 4'b0000 : {lead_zero[3:1], 1'b0};
`else
    assign blank = 4'b0000;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            presc_reg       <= '0;
            idx_reg         <= 2'd0;
            scan_active_reg <= 1'b0;
            NbOut           <= 4'd0;
            DigitEn         <= EN_IDLE;
        end else begin
            presc_reg <= tick ? '0 : presc_reg + PW'(1);
            if (tick) begin
                idx_reg         <= next_idx;
                scan_active_reg <= 1'b1;
                NbOut           <= digit_reg[next_idx];
                DigitEn         <= en_active ^ EN_IDLE;
            end
        end
    end

endmodule
